// File: rtl/fft_seq_ctrl.sv
// rtl/fft_seq_ctrl.sv - radix-2 FFT sequencer: bit-reversed load, N_2 butterfly stages over ping-pong banks
// Optional WINDOW_EN: adds win_idx and delays load writes one cycle to match hann_lut latency.
module fft_seq_ctrl #(
    parameter int N_2 = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_valid,
    output logic           load_ready,
    input  logic           start,
    output logic [N_2-1:0] rd_adra,
    output logic [N_2-1:0] rd_adrb,
    output logic [N_2-1:0] wr_adra,
    output logic [N_2-1:0] wr_adrb,
    output logic           we,
    output logic           rd_bank,
    output logic           load_sel,
    output logic [N_2-2:0] twiddle_idx,
    output logic           busy,
    output logic           done,
    output logic           result_bank
`ifdef WINDOW_EN
    ,
    output logic [N_2-1:0] win_idx
`endif
);

    localparam int N    = 1 << N_2;
    localparam int HALF = N / 2;
    localparam int SW   = $clog2(N_2 + 1);

    localparam logic [N_2-1:0] HALF_K   = N_2'(HALF);
    localparam logic [N_2-1:0] LAST_CNT = N_2'(N - 1);
    localparam logic [N_2-1:0] ONE_K    = N_2'(1);
    localparam logic [SW-1:0]  LAST_S   = SW'(N_2 - 1);
    localparam logic [SW-1:0]  ONE_S    = SW'(1);
    localparam logic           RES_BANK = 1'(N_2 % 2);

    typedef enum logic [1:0] {
        S_LOAD,
        S_READY,
        S_FFT
    } state_t;

    state_t         state;
    logic [N_2-1:0] cnt;
    logic [SW-1:0]  stage;
    logic [N_2-1:0] k;
    logic           fft_we_q;
    logic [N_2-1:0] fft_wa_q;
    logic [N_2-1:0] fft_wb_q;
    logic           done_q;
    logic           result_q;
`ifdef WINDOW_EN
    logic           ld_we_q;
    logic [N_2-1:0] ld_wa_q;
`endif

    logic           accept;
    logic           reading;
    logic [N_2-1:0] half;
    logic [N_2-1:0] mask;
    logic [N_2-1:0] base_a;
    logic [N_2-1:0] base_b;
    logic [N_2-2:0] tw;

    function automatic logic [N_2-1:0] bitrev(input logic [N_2-1:0] v);
        logic [N_2-1:0] r;
        for (int i = 0; i < N_2; i++) r[i] = v[N_2-1-i];
        return r;
    endfunction

    // k == HALF is the per-stage bubble: no read, only the last butterfly's write lands
    assign accept  = (state == S_LOAD) && load_valid;
    assign reading = (state == S_FFT) && (k != HALF_K);
    assign half    = ONE_K << stage;
    assign mask    = half - ONE_K;
    assign base_a  = ((k >> stage) << (stage + ONE_S)) | (k & mask);
    assign base_b  = base_a + half;
    assign tw      = (N_2-1)'((k & mask) << (LAST_S - stage));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_LOAD;
            cnt      <= '0;
            stage    <= '0;
            k        <= '0;
            fft_we_q <= 1'b0;
            fft_wa_q <= '0;
            fft_wb_q <= '0;
            done_q   <= 1'b0;
            result_q <= 1'b0;
`ifdef WINDOW_EN
            ld_we_q  <= 1'b0;
            ld_wa_q  <= '0;
`endif
        end else begin
            done_q   <= 1'b0;
            fft_we_q <= reading;
            fft_wa_q <= base_a;
            fft_wb_q <= base_b;
`ifdef WINDOW_EN
            ld_we_q  <= accept;
            ld_wa_q  <= bitrev(cnt);
`endif
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        cnt <= cnt + ONE_K;
                        if (cnt == LAST_CNT) state <= S_READY;
                    end
                end
                S_READY: begin
                    if (start) begin
                        state <= S_FFT;
                        stage <= '0;
                        k     <= '0;
                    end
                end
                S_FFT: begin
                    if (k == HALF_K) begin
                        k <= '0;
                        if (stage == LAST_S) begin
                            state    <= S_LOAD;
                            stage    <= '0;
                            done_q   <= 1'b1;
                            result_q <= RES_BANK;
                        end else begin
                            stage <= stage + ONE_S;
                        end
                    end else begin
                        k <= k + ONE_K;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    // Everything is gated by reset so outputs read 0 for the whole reset-low window
    always_comb begin
        load_ready  = 1'b0;
        rd_adra     = '0;
        rd_adrb     = '0;
        wr_adra     = '0;
        wr_adrb     = '0;
        we          = 1'b0;
        rd_bank     = 1'b0;
        load_sel    = 1'b0;
        twiddle_idx = '0;
        busy        = 1'b0;
        done        = 1'b0;
        result_bank = 1'b0;
`ifdef WINDOW_EN
        win_idx     = '0;
`endif
        if (reset) begin
            load_ready  = (state == S_LOAD);
            busy        = (state == S_FFT);
            done        = done_q;
            result_bank = result_q;
            load_sel    = (state == S_LOAD);
            if (state == S_FFT) rd_bank = stage[0];
            if (reading) begin
                rd_adra     = base_a;
                rd_adrb     = base_b;
                twiddle_idx = tw;
            end
            if (fft_we_q) begin
                we      = 1'b1;
                wr_adra = fft_wa_q;
                wr_adrb = fft_wb_q;
            end
`ifdef WINDOW_EN
            if (accept) win_idx = cnt;
            if (ld_we_q) begin
                we       = 1'b1;
                wr_adra  = ld_wa_q;
                load_sel = 1'b1;
            end
`else
            if (accept) begin
                we      = 1'b1;
                wr_adra = bitrev(cnt);
            end
`endif
        end
    end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb/tb_fft_seq_ctrl.sv - randomized self-checking bench for fft_seq_ctrl against a cycle-table model
module tb_fft_seq_ctrl;

    localparam int N_2    = 5;
    localparam int N      = 1 << N_2;
    localparam int HALF   = N / 2;
    localparam int SPS    = HALF + 1;
    localparam int LAST_W = N_2 * SPS;

    logic           clk;
    logic           reset;
    logic           load_valid;
    logic           load_ready;
    logic           start;
    logic [N_2-1:0] rd_adra;
    logic [N_2-1:0] rd_adrb;
    logic [N_2-1:0] wr_adra;
    logic [N_2-1:0] wr_adrb;
    logic           we;
    logic           rd_bank;
    logic           load_sel;
    logic [N_2-2:0] twiddle_idx;
    logic           busy;
    logic           done;
    logic           result_bank;
`ifdef WINDOW_EN
    logic [N_2-1:0] win_idx;
`endif

    int checks = 0;
    int errors = 0;

    int e_rv[0:127], e_ra[0:127], e_rb[0:127], e_tw[0:127], e_bank[0:127];
    int e_wv[0:127], e_wa[0:127], e_wb[0:127];

    fft_seq_ctrl #(.N_2(N_2)) dut (
        .clk(clk),
        .reset(reset),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .start(start),
        .rd_adra(rd_adra),
        .rd_adrb(rd_adrb),
        .wr_adra(wr_adra),
        .wr_adrb(wr_adrb),
        .we(we),
        .rd_bank(rd_bank),
        .load_sel(load_sel),
        .twiddle_idx(twiddle_idx),
        .busy(busy),
        .done(done),
        .result_bank(result_bank)
`ifdef WINDOW_EN
        ,
        .win_idx(win_idx)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int bitrev(input int v);
        int r = 0;
        for (int i = 0; i < N_2; i++) r |= ((v >> i) & 1) << (N_2 - 1 - i);
        return r;
    endfunction

    // Expected read/write activity per cycle after start, from the stage/butterfly schedule
    task automatic build_model();
        for (int c = 0; c < 128; c++) begin
            e_rv[c] = 0; e_ra[c] = 0; e_rb[c] = 0; e_tw[c] = 0; e_bank[c] = 0;
            e_wv[c] = 0; e_wa[c] = 0; e_wb[c] = 0;
        end
        for (int s = 0; s < N_2; s++) begin
            for (int k = 0; k < HALF; k++) begin
                int c = 1 + s * SPS + k;
                int h = 1 << s;
                int a = ((k >> s) << (s + 1)) | (k % h);
                e_rv[c] = 1; e_ra[c] = a; e_rb[c] = a + h;
                e_tw[c] = (k % h) * (HALF / h);
                e_bank[c] = s % 2;
                e_wv[c+1] = 1; e_wa[c+1] = a; e_wb[c+1] = a + h;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        logic any;
        any = load_ready | (|rd_adra) | (|rd_adrb) | (|wr_adra) | (|wr_adrb) | we | rd_bank
            | load_sel | (|twiddle_idx) | busy | done | result_bank;
        check(tag, int'(any), 0);
    endtask

    task automatic do_load();
        int acc = 0, prev_v = 0, prev_a = 0, guard = 0, v, n_idle;
        while (acc < N && guard < 400) begin
            v = ($urandom_range(0, 3) != 0) ? 1 : 0;
            load_valid = v[0];
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("ld_ready", load_ready, 1);
            check("ld_busy", busy, 0);
            check("ld_bank", rd_bank, 0);
            check("ld_sel", load_sel, 1);
`ifdef WINDOW_EN
            check("ld_we", we, prev_v);
            if (prev_v != 0) check("ld_wadr", wr_adra, prev_a);
            if (v != 0) check("win_idx", win_idx, acc);
`else
            check("ld_we", we, v);
            if (v != 0) check("ld_wadr", wr_adra, bitrev(acc));
`endif
            prev_v = v;
            prev_a = bitrev(acc);
            if (v != 0) acc++;
            guard++;
            tick();
        end
        if (acc < N) check("ld_timeout", acc, N);
        n_idle = $urandom_range(0, 2);
        for (int i = 0; i <= n_idle; i++) begin
            start = (i == n_idle);
            load_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rdy_ready", load_ready, 0);
            check("rdy_busy", busy, 0);
`ifdef WINDOW_EN
            if (i == 0) begin
                check("rdy_we_last", we, 1);
                check("rdy_wadr_last", wr_adra, N - 1);
                check("rdy_sel_last", load_sel, 1);
            end else begin
                check("rdy_we", we, 0);
            end
`else
            check("rdy_we", we, 0);
`endif
            tick();
        end
    endtask

    task automatic do_fft(input int abort_at);
        for (int c = 1; c <= LAST_W + 1; c++) begin
            load_valid = (c <= LAST_W) ? 1'($urandom_range(0, 1)) : 1'b0;
            start = 1'($urandom_range(0, 1));
            if (abort_at != 0 && c == abort_at) begin
                for (int r = 0; r < 3; r++) begin
                    reset = 1'b0;
                    @(negedge clk);
                    check_zero("rst_outputs_zero");
                    tick();
                end
                reset = 1'b1;
                load_valid = 1'b0;
                start = 1'b0;
                @(negedge clk);
                check("rst_ready", load_ready, 1);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_result_bank", result_bank, 0);
                tick();
                return;
            end
            @(negedge clk);
            check("fft_busy", busy, (c <= LAST_W) ? 1 : 0);
            check("fft_done", done, (c == LAST_W + 1) ? 1 : 0);
            check("fft_we", we, e_wv[c]);
            if (c <= LAST_W) begin
                check("fft_ready", load_ready, 0);
                check("fft_sel", load_sel, 0);
            end else begin
                check("end_ready", load_ready, 1);
                check("end_result_bank", result_bank, N_2 % 2);
            end
            if (e_wv[c] != 0) begin
                check("fft_wadra", wr_adra, e_wa[c]);
                check("fft_wadrb", wr_adrb, e_wb[c]);
            end
            if (e_rv[c] != 0) begin
                check("fft_radra", rd_adra, e_ra[c]);
                check("fft_radrb", rd_adrb, e_rb[c]);
                check("fft_twiddle", twiddle_idx, e_tw[c]);
                check("fft_bank", rd_bank, e_bank[c]);
            end
            if (c == 1 + 2 * SPS + 5) begin
                check("s2k5_radra", rd_adra, 9);
                check("s2k5_radrb", rd_adrb, 13);
                check("s2k5_twiddle", twiddle_idx, 4);
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b0;
        load_valid = 1'b0;
        start = 1'b0;
        build_model();
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_zero("init_outputs_zero");
            tick();
        end
        reset = 1'b1;
        do_load();
        do_fft(0);
        do_load();
        do_fft($urandom_range(5, 80));
        do_load();
        do_fft(0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_seq_ctrl.md
Name: fft_seq_ctrl

Overview:
Control and address-generation unit for the in-place radix-2 FFT core. It sequences the butterfly unit over a pair of ping-pong two-port RAM banks. It accepts N time-domain samples into bank 0 at bit-reversed addresses, runs N_2 butterfly stages at one butterfly per cycle, and reports which bank holds the natural-order result. It sits between the I2S sample stream and the fft_butterfly/twoport_RAM datapath and owns every RAM address, write enable and twiddle index.

Parameters:
N_2, 5, log2 of FFT length (N = 2**N_2 points)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
load_valid  in  1  sample present on the datapath sample bus
load_ready  out  1  controller accepts a sample this cycle
start  in  1  begin FFT on the loaded frame
rd_adra  out  N_2  read address, butterfly A operand
rd_adrb  out  N_2  read address, butterfly B operand
wr_adra  out  N_2  write address, port A
wr_adrb  out  N_2  write address, port B
we  out  1  RAM write enable (both ports)
rd_bank  out  1  bank being read; write bank is ~rd_bank during FFT
load_sel  out  1  1: RAM write data = sample bus; 0: butterfly outputs
twiddle_idx  out  N_2-1  twiddle ROM index for the current read
busy  out  1  high in the FFT state
done  out  1  one-cycle pulse after the final write
result_bank  out  1  bank holding the finished spectrum

Behaviour:
- States: LOAD, READY, FFT. Reset (reset==0 at a clk edge) forces LOAD from any state, including mid-FFT. All counters clear. All outputs are 0 while reset is low.
- LOAD:
  - load_ready=1, load_sel=1, rd_bank=0.
  - On load_valid&&load_ready: we=1, wr_adra=bitrev(cnt) in the same cycle. cnt increments.
  - After the N-th accepted sample, go to READY.
- READY: load_ready=0. A start pulse moves to FFT. start is ignored in LOAD and FFT. load_valid is ignored outside LOAD.
- FFT, stage s=0..N_2-1, butterfly k=0..N/2-1 (one per cycle):
  - half=1<<s
  - rd_adra=((k>>s)<<(s+1))|(k&(half-1))
  - rd_adrb=rd_adra+half
  - twiddle_idx=(k&(half-1))<<(N_2-1-s)
  - rd_bank=s%2
- RAM read latency is 1 cycle. wr_adra/wr_adrb are rd_adra/rd_adrb registered one cycle, and we is asserted in that following cycle.
- One bubble cycle after each stage (no read, we from the last butterfly only). This prevents the next stage reading a bank in the same cycle it is written. Cost: N/2+1 cycles per stage.
- Timing, with start sampled in cycle 0:
  - the read for stage s, butterfly k occurs in cycle 1+s*(N/2+1)+k
  - the last write occurs in cycle N_2*(N/2+1)
  - done pulses in the next cycle, and the state returns to LOAD in that cycle
  - for N_2=5: last write in cycle 85, done in cycle 86
- result_bank = N_2%2. It is set when done pulses and held until the next done or reset.
- busy=1 exactly in the FFT state. done and load_ready are never high together with busy.

Optional Feature:
WINDOW_EN:
- Adds output win_idx [N_2-1:0], equal to cnt of the sample accepted this cycle, which drives hann_lut.
- The LOAD write (we, wr_adra) is delayed by one registered cycle to align with hann_lut's one-cycle output latency.
- The N-th write therefore lands in the first READY cycle. A start accepted in that cycle still yields the first FFT read one cycle later.
- Without the macro: no win_idx, and the write happens in the accept cycle.

Test Plan:
1. Reset low 3 cycles during FFT, then high -> state LOAD, all outputs 0 while reset low, load_ready=1 on the first cycle after release, cnt=0.
2. N_2=5, 32 consecutive load_valid -> wr_adra sequence 0,16,8,24,4,...,31, we=1 each cycle, load_ready=0 after the 32nd.
3. start in READY -> cycle 1: rd_adra=0, rd_adrb=1, twiddle_idx=0, rd_bank=0; cycle 2: we=1, wr_adra=0, wr_adrb=1; stage 2 butterfly 5 reads 9/13 with twiddle_idx=4.
4. Full run -> stage bubbles in cycles 17,34,51,68; done pulses only in cycle 86; result_bank=1; busy high in cycles 1..85.
5. start during LOAD and load_valid during FFT -> both ignored, addresses unaffected.
6. WINDOW_EN defined -> win_idx=0..31 during load, each write one cycle after its accept, done still in cycle 86.
